// File: rtl/id_ex_pipe_ctrl.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// It also handles load-use bubbles, the multi-cycle multiply hold and branch flush.
module id_ex_pipe_ctrl #(
    parameter int MULT_LAT = 3,
    parameter int DW       = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic [2:0]    Branch_i,
    input  logic          MemtoReg_i,
    input  logic          RegWrite_i,
    input  logic          ALUsrc_i,
    input  logic          Mem_Read_i,
    input  logic          Mem_Write_i,
    input  logic [3:0]    ALUCtrl_i,
    input  logic [4:0]    Read1_i,
    input  logic [4:0]    Read2_i,
    input  logic [4:0]    Write_addr_i,
    input  logic [DW-1:0] RS_data_i,
    input  logic [DW-1:0] RT_data_i,
    input  logic [DW-1:0] Imm_i,
    input  logic [DW-1:0] PC4_i,
    output logic [2:0]    Branch_o,
    output logic          MemtoReg_o,
    output logic          RegWrite_o,
    output logic          ALUsrc_o,
    output logic          Mem_Read_o,
    output logic          Mem_Write_o,
    output logic [3:0]    ALUCtrl_o,
    output logic [4:0]    Read1_o,
    output logic [4:0]    Read2_o,
    output logic [4:0]    Write_addr_o,
    output logic [DW-1:0] RS_data_o,
    output logic [DW-1:0] RT_data_o,
    output logic [DW-1:0] Imm_o,
    output logic [DW-1:0] PC4_o,
    output logic          valid_o,
    output logic          stall_o
);

    localparam logic [3:0] MULT_OP  = 4'd13;
    localparam logic [3:0] MULT_END = 4'(MULT_LAT - 1);

    logic [3:0] cnt;
    logic       ex_is_mult;
    logic       mult_busy;
    logic       load_use;
    logic       bubble;

    assign ex_is_mult = valid_o & (ALUCtrl_o == MULT_OP);
    assign mult_busy  = ex_is_mult & (cnt != MULT_END);
    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign load_use   = valid_o & Mem_Read_o & (Write_addr_o != 5'd0) &
                        ((Write_addr_o == Read1_i) | (Write_addr_o == Read2_i));
    assign stall_o    = ~flush_i & (mult_busy | load_use);

    // Reset, flush and load-use all leave an empty slot; a busy mult outranks load-use.
    assign bubble = rst_i | flush_i | (~mult_busy & load_use);

    always_ff @(posedge clk_i) begin
        if (bubble) begin
            Branch_o     <= '0;
            MemtoReg_o   <= 1'b0;
            RegWrite_o   <= 1'b0;
            ALUsrc_o     <= 1'b0;
            Mem_Read_o   <= 1'b0;
            Mem_Write_o  <= 1'b0;
            ALUCtrl_o    <= '0;
            Read1_o      <= '0;
            Read2_o      <= '0;
            Write_addr_o <= '0;
            RS_data_o    <= '0;
            RT_data_o    <= '0;
            Imm_o        <= '0;
            PC4_o        <= '0;
            valid_o      <= 1'b0;
            cnt          <= '0;
        end else if (mult_busy) begin
            if (cnt != 4'hF) begin
                cnt <= cnt + 4'd1;
            end
        end else begin
            Branch_o     <= Branch_i;
            MemtoReg_o   <= MemtoReg_i;
            RegWrite_o   <= RegWrite_i;
            ALUsrc_o     <= ALUsrc_i;
            Mem_Read_o   <= Mem_Read_i;
            Mem_Write_o  <= Mem_Write_i;
            ALUCtrl_o    <= ALUCtrl_i;
            Read1_o      <= Read1_i;
            Read2_o      <= Read2_i;
            Write_addr_o <= Write_addr_i;
            RS_data_o    <= RS_data_i;
            RT_data_o    <= RT_data_i;
            Imm_o        <= Imm_i;
            PC4_o        <= PC4_i;
            valid_o      <= 1'b1;
            cnt          <= '0;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// Directed bench for id_ex_pipe_ctrl: per-cycle expected EX state pushed by the driver,
// popped and compared by an independent monitor on the falling edge.
module tb_id_ex_pipe_ctrl;

    localparam int DW = 32;

    typedef struct packed {
        logic [2:0]    branch;
        logic          memtoreg;
        logic          regwrite;
        logic          alusrc;
        logic          mem_read;
        logic          mem_write;
        logic [3:0]    aluctrl;
        logic [4:0]    read1;
        logic [4:0]    read2;
        logic [4:0]    write_addr;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc4;
    } id_t;

    localparam int IW = $bits(id_t);
    localparam int EW = IW + 2;

    logic          clk;
    logic          rst;
    logic          flush;
    id_t           id_in;
    id_t           ex_act;
    logic          valid;
    logic          stall;
    logic [2:0]    branch_o;
    logic          memtoreg_o, regwrite_o, alusrc_o, mem_read_o, mem_write_o;
    logic [3:0]    aluctrl_o;
    logic [4:0]    read1_o, read2_o, write_addr_o;
    logic [DW-1:0] rs_o, rt_o, imm_o, pc4_o;

    logic [EW-1:0] exp_q[$];
    int            step_q[$];
    int            checks = 0;
    int            errors = 0;
    int            step_no = 0;

    id_ex_pipe_ctrl #(.MULT_LAT(3), .DW(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .Branch_i     (id_in.branch),
        .MemtoReg_i   (id_in.memtoreg),
        .RegWrite_i   (id_in.regwrite),
        .ALUsrc_i     (id_in.alusrc),
        .Mem_Read_i   (id_in.mem_read),
        .Mem_Write_i  (id_in.mem_write),
        .ALUCtrl_i    (id_in.aluctrl),
        .Read1_i      (id_in.read1),
        .Read2_i      (id_in.read2),
        .Write_addr_i (id_in.write_addr),
        .RS_data_i    (id_in.rs_data),
        .RT_data_i    (id_in.rt_data),
        .Imm_i        (id_in.imm),
        .PC4_i        (id_in.pc4),
        .Branch_o     (branch_o),
        .MemtoReg_o   (memtoreg_o),
        .RegWrite_o   (regwrite_o),
        .ALUsrc_o     (alusrc_o),
        .Mem_Read_o   (mem_read_o),
        .Mem_Write_o  (mem_write_o),
        .ALUCtrl_o    (aluctrl_o),
        .Read1_o      (read1_o),
        .Read2_o      (read2_o),
        .Write_addr_o (write_addr_o),
        .RS_data_o    (rs_o),
        .RT_data_o    (rt_o),
        .Imm_o        (imm_o),
        .PC4_o        (pc4_o),
        .valid_o      (valid),
        .stall_o      (stall)
    );

    assign ex_act = {branch_o, memtoreg_o, regwrite_o, alusrc_o, mem_read_o, mem_write_o,
                     aluctrl_o, read1_o, read2_o, write_addr_o, rs_o, rt_o, imm_o, pc4_o};

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic id_t mk(input logic [2:0] br, input logic m2r, input logic rw,
                               input logic asrc, input logic mr, input logic mw,
                               input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] wa, input logic [DW-1:0] rs,
                               input logic [DW-1:0] rt, input logic [DW-1:0] im,
                               input logic [DW-1:0] pc);
        id_t t;
        t = {br, m2r, rw, asrc, mr, mw, op, r1, r2, wa, rs, rt, im, pc};
        return t;
    endfunction

    function automatic id_t rand_id();
        id_t t;
        t.branch     = 3'($urandom_range(0, 4));
        t.memtoreg   = 1'($urandom_range(0, 1));
        t.regwrite   = 1'($urandom_range(0, 1));
        t.alusrc     = 1'($urandom_range(0, 1));
        t.mem_read   = 1'($urandom_range(0, 1));
        t.mem_write  = 1'($urandom_range(0, 1));
        t.aluctrl    = 4'($urandom_range(0, 15));
        t.read1      = 5'($urandom_range(0, 31));
        t.read2      = 5'($urandom_range(0, 31));
        t.write_addr = 5'($urandom_range(0, 31));
        t.rs_data    = $urandom;
        t.rt_data    = $urandom;
        t.imm        = $urandom;
        t.pc4        = $urandom;
        return t;
    endfunction

    // Driver: apply one cycle of ID inputs and queue the EX state and stall expected in that cycle
    task automatic step(input id_t in, input logic fl, input logic rs,
                        input id_t ex, input logic v, input logic st);
        id_in = in;
        flush = fl;
        rst   = rs;
        exp_q.push_back({ex, v, st});
        step_q.push_back(step_no);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            int            s;
            id_t           e_ex;
            e    = exp_q.pop_front();
            s    = step_q.pop_front();
            e_ex = e[EW-1:2];
            checks++;
            if (ex_act !== e_ex) begin
                errors++;
                $display("FAIL ex_fields step %0d: actual=%h required=%h", s, ex_act, e_ex);
            end
            checks++;
            if (valid !== e[1]) begin
                errors++;
                $display("FAIL valid step %0d: actual=%b required=%b", s, valid, e[1]);
            end
            checks++;
            if (stall !== e[0]) begin
                errors++;
                $display("FAIL stall step %0d: actual=%b required=%b", s, stall, e[0]);
            end
        end
    end

    id_t bub, addi, lw, add, lw0, addz, mult, mult2, sw, beq, lw2, cons;

    initial begin
        bub   = '0;
        addi  = mk(3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2,  5'd8,  5'd0, 5'd9,  32'h11, 32'h22, 32'd5,  32'h104);
        lw    = mk(3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2,  5'd29, 5'd0, 5'd9,  32'h33, 32'h0,  32'd8,  32'h108);
        add   = mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  5'd9,  5'd10, 5'd11, 32'h44, 32'h55, 32'h0,  32'h10c);
        lw0   = mk(3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2,  5'd29, 5'd0, 5'd0,  32'h66, 32'h0,  32'd12, 32'h110);
        addz  = mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  5'd0,  5'd5, 5'd12, 32'h0,  32'h77, 32'h0,  32'h114);
        mult  = mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd13, 5'd4,  5'd5, 5'd6,  32'h7,  32'h9,  32'h0,  32'h118);
        mult2 = mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd13, 5'd6,  5'd7, 5'd8,  32'h3f, 32'h2,  32'h0,  32'h11c);
        sw    = mk(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2,  5'd29, 5'd6, 5'd0,  32'h88, 32'h3f, 32'd4,  32'h120);
        beq   = mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6,  5'd1,  5'd2, 5'd0,  32'h1,  32'h1,  32'hfff0, 32'h124);
        lw2   = mk(3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2,  5'd29, 5'd0, 5'd3,  32'h99, 32'h0,  32'd16, 32'h128);
        cons  = mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  5'd14, 5'd3, 5'd15, 32'haa, 32'hbb, 32'h0,  32'h12c);

        // First reset cycle: state still unknown, nothing queued
        id_in = rand_id();
        flush = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        //    ID input  flush rst   EX expected valid stall
        step(rand_id(), 1'b0, 1'b1, bub,   1'b0, 1'b0);  // reset state held
        step(addi,      1'b0, 1'b0, bub,   1'b0, 1'b0);  // first edge after release
        step(lw,        1'b0, 1'b0, addi,  1'b1, 1'b0);  // pass-through
        step(add,       1'b0, 1'b0, lw,    1'b1, 1'b1);  // load-use via Read1
        step(add,       1'b0, 1'b0, bub,   1'b0, 1'b0);  // one bubble
        step(lw0,       1'b0, 1'b0, add,   1'b1, 1'b0);
        step(addz,      1'b0, 1'b0, lw0,   1'b1, 1'b0);  // load to r0: no stall
        step(mult,      1'b0, 1'b0, addz,  1'b1, 1'b0);
        step(mult2,     1'b0, 1'b0, mult,  1'b1, 1'b1);  // mult hold cycle 1
        step(mult2,     1'b0, 1'b0, mult,  1'b1, 1'b1);  // mult hold cycle 2
        step(mult2,     1'b0, 1'b0, mult,  1'b1, 1'b0);  // last mult cycle
        step(sw,        1'b0, 1'b0, mult2, 1'b1, 1'b1);  // back-to-back mult
        step(sw,        1'b0, 1'b0, mult2, 1'b1, 1'b1);
        step(sw,        1'b0, 1'b0, mult2, 1'b1, 1'b0);  // dependent store, no bubble
        step(lw,        1'b0, 1'b0, sw,    1'b1, 1'b0);
        step(mult,      1'b0, 1'b0, lw,    1'b1, 1'b0);  // lw in EX, mult in ID, no match
        step(beq,       1'b0, 1'b0, mult,  1'b1, 1'b1);
        step(beq,       1'b1, 1'b0, mult,  1'b1, 1'b0);  // flush during 2nd hold cycle
        step(beq,       1'b0, 1'b0, bub,   1'b0, 1'b0);
        step(mult,      1'b0, 1'b0, beq,   1'b1, 1'b0);
        step(addi,      1'b0, 1'b0, mult,  1'b1, 1'b1);
        step(addi,      1'b0, 1'b1, mult,  1'b1, 1'b1);  // reset mid-hold
        step(addi,      1'b0, 1'b0, bub,   1'b0, 1'b0);
        step(lw2,       1'b0, 1'b0, addi,  1'b1, 1'b0);
        step(cons,      1'b1, 1'b0, lw2,   1'b1, 1'b0);  // flush beats load-use
        step(addi,      1'b0, 1'b0, bub,   1'b0, 1'b0);
        step(lw2,       1'b0, 1'b0, addi,  1'b1, 1'b0);
        step(cons,      1'b0, 1'b0, lw2,   1'b1, 1'b1);  // load-use via Read2
        step(cons,      1'b0, 1'b0, bub,   1'b0, 1'b0);
        step(bub,       1'b0, 1'b0, cons,  1'b1, 1'b0);
        step(bub,       1'b0, 1'b0, bub,   1'b1, 1'b0);  // captured all-zero instruction

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_ctrl.md
Name: id_ex_pipe_ctrl

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath.
- Captures the instruction decoder's control fields and the register-file/immediate operands each cycle, and presents them to the EX stage.
- Contains the interlock logic:
  - load-use bubble insertion;
  - multi-cycle multiply hold (ALU control 13);
  - branch flush.
- Drives a single stall output that freezes the PC and the IF/ID register.

Parameters:
- MULT_LAT, 3, cycles a mult occupies EX (1..15); 1 means no hold.
- DW, 32, datapath width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- flush_i  input  1  taken branch resolved downstream; kill the instruction entering EX.
- Branch_i  input  3  branch kind (0 none, 1 beq, 2 bne, 3 bgt, 4 bge).
- MemtoReg_i, RegWrite_i, ALUsrc_i, Mem_Read_i, Mem_Write_i  input  1 each  decoder controls.
- ALUCtrl_i  input  4  ALU operation code.
- Read1_i, Read2_i  input  5 each  source register numbers; 0 means unused.
- Write_addr_i  input  5  destination register.
- RS_data_i, RT_data_i, Imm_i, PC4_i  input  DW each  operands, sign-extended immediate, PC+4.
- Each ID input X_i has an EX output X_o of the same width (Branch_o … PC4_o).
- valid_o  output  1  EX slot holds a real instruction.
- stall_o  output  1  hold PC and IF/ID this cycle (combinational).

Behaviour:
- Reset (rst_i=1 at edge):
  - All registered outputs go to 0, valid_o=0.
  - Multiply counter goes to 0.
  - stall_o=0 in the cycle after reset.
- Internal signals:
  - ex_is_mult = valid_o & (ALUCtrl_o==13).
  - mult_busy = ex_is_mult & (cnt != MULT_LAT-1). cnt is 4 bits, saturating.
  - load_use = valid_o & Mem_Read_o & (Write_addr_o!=0) & ((Write_addr_o==Read1_i) | (Write_addr_o==Read2_i)). Register 0 never matches.
  - stall_o = ~flush_i & (mult_busy | load_use).
- Edge actions, in priority order:
  1. rst_i: reset as above.
  2. flush_i: insert a bubble. All control outputs (Branch, MemtoReg, RegWrite, ALUsrc, Mem_Read, Mem_Write, ALUCtrl, Write_addr) go to 0, data outputs go to 0, valid_o=0, cnt=0. An in-progress mult is aborted.
  3. mult_busy: hold every EX output unchanged; cnt increments.
  4. load_use: insert a bubble (as in 2). ID is held upstream by stall_o, so the consumer re-presents next cycle.
  5. Otherwise: capture all ID inputs; valid_o=1; cnt=0.
- Latency and occupancy:
  - Normal path: ID to EX is 1 cycle.
  - A mult occupies EX for exactly MULT_LAT cycles, with stall_o high for MULT_LAT-1 of them.
  - A load-use hazard costs exactly 1 bubble cycle.
- Boundary cases:
  - Back-to-back mults: the second waits in ID while the first holds. It then enters and holds for its own MULT_LAT cycles.
  - A lw in EX while a mult is waiting in ID: the load-use check applies only to the ID fields, so no bubble unless registers match.
  - A mult in EX with a dependent consumer in ID: handled by the hold. No bubble is needed afterwards, because the mult result is forwarded.
  - MULT_LAT=1: mult_busy is never asserted.
  - A bubble must never assert RegWrite_o or Mem_Write_o.
  - Reset asserted mid-hold: the next cycle shows the reset state, and stall_o drops immediately.

Test Plan:
- Reset: rst_i=1 for 2 cycles with random ID inputs → all outputs 0, valid_o=0, stall_o=0; first edge after release captures ID fields.
- Pass-through: addi, Read1=8, Write_addr=9, Imm=5, ALUCtrl=2, ALUsrc=1 → EX outputs equal these values one cycle later; valid_o=1; stall_o stays 0.
- Load-use: lw with Write_addr=9 in EX, then add with Read1=9 in ID → stall_o=1 for 1 cycle, EX shows a bubble (RegWrite_o=0, valid_o=0), then the add enters. With Write_addr=0 → no stall.
- Multiply hold: mult enters EX with MULT_LAT=3 → EX outputs constant for 3 cycles, stall_o=1 for cycles 1–2, next instruction enters on the 3rd edge.
- Flush: flush_i=1 during the 2nd cycle of a mult hold → next edge EX shows a bubble, cnt=0, stall_o=0 in the flush cycle.
- Flush with load-use: flush_i and load_use both true → bubble, stall_o=0; ID advances normally.
